// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pattern scheduler.
// Holds the scheduler state encoding and the wrapping pattern-step helper.
package vga_pkg;

    localparam int PAT_W   = 2;
    localparam int RGB_W   = 16;
    localparam int DWELL_W = 10;

    localparam logic [RGB_W-1:0] COLOR_BLACK = 16'h0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        AUTO   = 2'd1,
        MANUAL = 2'd2
    } state_t;

    // Next pattern index, wrapping from the last source back to 0.
    function automatic logic [PAT_W-1:0] pat_step(
        input logic [PAT_W-1:0] cur,
        input int               num_pat
    );
        logic [PAT_W-1:0] last;
        last = PAT_W'(num_pat - 1);
        if (cur == last) begin
            return {PAT_W{1'b0}};
        end else begin
            return cur + PAT_W'(1);
        end
    endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Registered falling-edge detector for vsync; emits a one-cycle frame_start.
// History resets high so a reset release is never mistaken for a falling edge.
module vga_edge_det (
    input  logic vga_clk,
    input  logic rst_n,
    input  logic vsync,
    output logic frame_start
);

    logic vsync_q_r;
    logic frame_start_r;

    // Capture vsync history and flag the high-to-low transition.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q_r     <= 1'b1;
            frame_start_r <= 1'b0;
        end else begin
            vsync_q_r     <= vsync;
            frame_start_r <= vsync_q_r & ~vsync;
        end
    end

    assign frame_start = frame_start_r;

endmodule

// File: rtl/vga_pat_sched.sv
// Pattern scheduler: selects one of four RGB565 sources, stepping on frame
// boundaries either after a dwell time (auto) or on key request (manual).
module vga_pat_sched
    import vga_pkg::*;
#(
    parameter int DWELL_FRAMES = 60,
    parameter int NUM_PAT      = 4
) (
    input  logic             vga_clk,
    input  logic             rst_n,
    input  logic             vsync,
    input  logic             key_next,
    input  logic             key_mode,
    input  logic [RGB_W-1:0] pix_data0,
    input  logic [RGB_W-1:0] pix_data1,
    input  logic [RGB_W-1:0] pix_data2,
    input  logic [RGB_W-1:0] pix_data3,
    output logic [RGB_W-1:0] pix_data,
    output logic [PAT_W-1:0] pat_sel,
    output logic             auto_mode,
    output logic             frame_start
);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_FRAMES - 1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [PAT_W-1:0]   pat_sel_r;
    logic [PAT_W-1:0]   pat_sel_nxt_s;
    logic [PAT_W-1:0]   pat_inc_s;
    logic [DWELL_W-1:0] dwell_cnt_r;
    logic [DWELL_W-1:0] dwell_nxt_s;
    logic               pending_r;
    logic               pending_nxt_s;
    logic [RGB_W-1:0]   pix_sel_s;
    logic [RGB_W-1:0]   pix_data_r;
    logic               auto_mode_r;
    logic               frame_start_s;

    vga_edge_det u_edge_det (
        .vga_clk     (vga_clk),
        .rst_n       (rst_n),
        .vsync       (vsync),
        .frame_start (frame_start_s)
    );

    assign pat_inc_s = pat_step(pat_sel_r, NUM_PAT);

    // Mode FSM, dwell counter and pending-step flag. key_mode always wins
    // over key_next; an auto expiry step still lands on the mode-change cycle.
    always_comb begin
        state_nxt_s   = state_r;
        pat_sel_nxt_s = pat_sel_r;
        dwell_nxt_s   = dwell_cnt_r;
        pending_nxt_s = pending_r;
        case (state_r)
            IDLE: begin
                if (frame_start_s) begin
                    state_nxt_s   = AUTO;
                    dwell_nxt_s   = {DWELL_W{1'b0}};
                    pending_nxt_s = 1'b0;
                end else begin
                    state_nxt_s   = IDLE;
                end
            end
            AUTO: begin
                if (frame_start_s) begin
                    if (dwell_cnt_r == DWELL_LAST) begin
                        pat_sel_nxt_s = pat_inc_s;
                        dwell_nxt_s   = {DWELL_W{1'b0}};
                    end else begin
                        dwell_nxt_s   = dwell_cnt_r + DWELL_W'(1);
                    end
                end else begin
                    dwell_nxt_s = dwell_cnt_r;
                end
                if (key_mode) begin
                    state_nxt_s   = MANUAL;
                    dwell_nxt_s   = {DWELL_W{1'b0}};
                    pending_nxt_s = 1'b0;
                end else begin
                    state_nxt_s   = AUTO;
                    pending_nxt_s = 1'b0;
                end
            end
            MANUAL: begin
                if (key_mode) begin
                    state_nxt_s   = AUTO;
                    dwell_nxt_s   = {DWELL_W{1'b0}};
                    pending_nxt_s = 1'b0;
                end else if (frame_start_s) begin
                    if (pending_r || key_next) begin
                        pat_sel_nxt_s = pat_inc_s;
                    end else begin
                        pat_sel_nxt_s = pat_sel_r;
                    end
                    pending_nxt_s = 1'b0;
                end else begin
                    pending_nxt_s = pending_r | key_next;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                pat_sel_nxt_s = {PAT_W{1'b0}};
                dwell_nxt_s   = {DWELL_W{1'b0}};
                pending_nxt_s = 1'b0;
            end
        endcase
    end

    // Source mux; black is forced until the first frame boundary.
    always_comb begin
        pix_sel_s = COLOR_BLACK;
        if (state_r == IDLE) begin
            pix_sel_s = COLOR_BLACK;
        end else begin
            case (pat_sel_r)
                2'd0:    pix_sel_s = pix_data0;
                2'd1:    pix_sel_s = pix_data1;
                2'd2:    pix_sel_s = pix_data2;
                2'd3:    pix_sel_s = pix_data3;
                default: pix_sel_s = COLOR_BLACK;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            pat_sel_r   <= {PAT_W{1'b0}};
            dwell_cnt_r <= {DWELL_W{1'b0}};
            pending_r   <= 1'b0;
            pix_data_r  <= COLOR_BLACK;
            auto_mode_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pat_sel_r   <= pat_sel_nxt_s;
            dwell_cnt_r <= dwell_nxt_s;
            pending_r   <= pending_nxt_s;
            pix_data_r  <= pix_sel_s;
            auto_mode_r <= (state_nxt_s == AUTO);
        end
    end

    assign pix_data    = pix_data_r;
    assign pat_sel     = pat_sel_r;
    assign auto_mode   = auto_mode_r;
    assign frame_start = frame_start_s;

endmodule

// File: tb/tb_vga_pat_sched.sv
// Directed bench for vga_pat_sched with DWELL_FRAMES = 3 and constant sources.
// Expected pattern/mode per boundary is queued at drive time and popped after.
module tb_vga_pat_sched;

    logic        vga_clk;
    logic        rst_n;
    logic        vsync;
    logic        key_next;
    logic        key_mode;
    logic [15:0] pix_data0;
    logic [15:0] pix_data1;
    logic [15:0] pix_data2;
    logic [15:0] pix_data3;
    logic [15:0] pix_data;
    logic [1:0]  pat_sel;
    logic        auto_mode;
    logic        frame_start;

    typedef struct packed {
        logic [1:0] pat;
        logic       auto_m;
    } sb_t;

    sb_t        sb[$];
    int         n_checks = 0;
    int         n_errs   = 0;
    logic [1:0] cur_pat  = 2'd0;

    vga_pat_sched #(.DWELL_FRAMES(3), .NUM_PAT(4)) dut (
        .vga_clk     (vga_clk),
        .rst_n       (rst_n),
        .vsync       (vsync),
        .key_next    (key_next),
        .key_mode    (key_mode),
        .pix_data0   (pix_data0),
        .pix_data1   (pix_data1),
        .pix_data2   (pix_data2),
        .pix_data3   (pix_data3),
        .pix_data    (pix_data),
        .pat_sel     (pat_sel),
        .auto_mode   (auto_mode),
        .frame_start (frame_start)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    function automatic logic [15:0] color(input logic [1:0] p);
        case (p)
            2'd0:    return 16'hF800;
            2'd1:    return 16'h07E0;
            2'd2:    return 16'h001F;
            default: return 16'hFFFF;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge vga_clk);
    endtask

    // One vsync fall; optional keys driven during the frame_start cycle.
    task automatic boundary(input string tag, input logic kn, input logic km,
                            input logic [1:0] exp_pat, input logic exp_auto);
        sb_t e;
        e.pat    = exp_pat;
        e.auto_m = exp_auto;
        sb.push_back(e);
        vsync = 1'b0;
        step();
        vsync    = 1'b1;
        key_next = kn;
        key_mode = km;
        chk({tag, "_fs_hi"}, 16'(frame_start), 16'd1);
        chk({tag, "_hold"}, 16'(pat_sel), 16'(cur_pat));
        step();
        key_next = 1'b0;
        key_mode = 1'b0;
        chk({tag, "_fs_lo"}, 16'(frame_start), 16'd0);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 16'd1, 16'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_pat"}, 16'(pat_sel), 16'(e.pat));
            chk({tag, "_auto"}, 16'(auto_mode), 16'(e.auto_m));
            step();
            chk({tag, "_pix"}, pix_data, color(e.pat));
            cur_pat = e.pat;
        end
        repeat (3) step();
    endtask

    initial begin
        rst_n     = 1'b0;
        vsync     = 1'b1;
        key_next  = 1'b0;
        key_mode  = 1'b0;
        pix_data0 = 16'hF800;
        pix_data1 = 16'h07E0;
        pix_data2 = 16'h001F;
        pix_data3 = 16'hFFFF;
        repeat (2) step();
        chk("rst_pat", 16'(pat_sel), 16'd0);
        chk("rst_pix", pix_data, 16'h0000);
        chk("rst_auto", 16'(auto_mode), 16'd0);
        chk("rst_fs", 16'(frame_start), 16'd0);
        rst_n = 1'b1;
        repeat (3) step();
        chk("release_no_fs", 16'(frame_start), 16'd0);

        // Keys in IDLE must do nothing.
        key_mode = 1'b1;
        step();
        key_mode = 1'b0;
        key_next = 1'b1;
        step();
        key_next = 1'b0;
        step();
        chk("idle_auto", 16'(auto_mode), 16'd0);
        chk("idle_pix", pix_data, 16'h0000);

        boundary("b0", 1'b0, 1'b0, 2'd0, 1'b1);

        // Dwell of 3: steps on the 3rd and 6th boundaries.
        boundary("a1", 1'b0, 1'b0, 2'd0, 1'b1);
        boundary("a2", 1'b0, 1'b0, 2'd0, 1'b1);
        boundary("a3", 1'b0, 1'b0, 2'd1, 1'b1);
        boundary("a4", 1'b0, 1'b0, 2'd1, 1'b1);
        boundary("a5", 1'b0, 1'b0, 2'd1, 1'b1);
        boundary("a6", 1'b0, 1'b0, 2'd2, 1'b1);
        boundary("a7", 1'b0, 1'b0, 2'd2, 1'b1);

        key_mode = 1'b1;
        step();
        key_mode = 1'b0;
        chk("to_manual", 16'(auto_mode), 16'd0);
        for (int i = 0; i < 3; i++) begin
            key_next = 1'b1;
            step();
            key_next = 1'b0;
            step();
        end
        boundary("m_step", 1'b0, 1'b0, 2'd3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            boundary("m_hold", 1'b0, 1'b0, 2'd3, 1'b0);
        end

        boundary("m_wrap", 1'b1, 1'b0, 2'd0, 1'b0);
        key_mode = 1'b1;
        key_next = 1'b1;
        step();
        key_mode = 1'b0;
        key_next = 1'b0;
        chk("km_wins", 16'(auto_mode), 16'd1);
        boundary("km_nostep", 1'b0, 1'b0, 2'd0, 1'b1);
        boundary("r1", 1'b0, 1'b0, 2'd0, 1'b1);
        boundary("r2", 1'b0, 1'b0, 2'd1, 1'b1);
        boundary("r3", 1'b0, 1'b0, 2'd1, 1'b1);
        boundary("r4", 1'b0, 1'b0, 2'd1, 1'b1);
        boundary("r5", 1'b0, 1'b0, 2'd2, 1'b1);

        // Asynchronous reset away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pat", 16'(pat_sel), 16'd0);
        chk("arst_pix", pix_data, 16'h0000);
        chk("arst_auto", 16'(auto_mode), 16'd0);
        chk("arst_fs", 16'(frame_start), 16'd0);
        step();
        rst_n   = 1'b1;
        cur_pat = 2'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_no_fs", 16'(frame_start), 16'd0);
        end
        boundary("p0", 1'b0, 1'b0, 2'd0, 1'b1);
        boundary("p1", 1'b0, 1'b0, 2'd0, 1'b1);
        boundary("p2", 1'b0, 1'b0, 2'd0, 1'b1);
        // key_mode on an expiry boundary: step still happens, then manual.
        boundary("km_expiry", 1'b0, 1'b1, 2'd1, 1'b0);
        boundary("km_expiry_hold", 1'b0, 1'b0, 2'd1, 1'b0);

        chk("sb_drained", 16'(sb.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/vga_pat_sched.md
VGA_PAT_SCHED -- requirements
Module: vga_pat_sched

Interface
REQ-001 SHALL have parameter DWELL_FRAMES, default 60, frames each pattern is shown in auto mode (legal range 1..1023).
REQ-002 SHALL have parameter NUM_PAT, default 4, number of pattern sources (fixed at 4 in this revision).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: port vga_clk (input, 1, pixel clock, all logic on rising edge) and port rst_n (input, 1, asynchronous active-low reset).
REQ-004 SHALL have port vsync  input  1  sync from vga_ctrl, active-low pulse.
REQ-005 SHALL have port key_next  input  1  one-cycle pulse, debounced upstream, request next pattern.
REQ-006 SHALL have port key_mode  input  1  one-cycle pulse, debounced upstream, toggle auto/manual.
REQ-007 SHALL have ports pix_data0..pix_data3  input  16 each  RGB565 from the pattern sources.
REQ-008 SHALL have port pix_data  output  16  selected RGB565 to vga_ctrl.
REQ-009 SHALL have port pat_sel  output  2  currently displayed pattern index.
REQ-010 SHALL have port auto_mode  output  1  high when in AUTO state.
REQ-011 SHALL have port frame_start  output  1  one-cycle pulse per frame boundary.

Function
REQ-012 SHALL define the frame boundary as the cycle after vsync is sampled high then low (falling edge, registered); frame_start SHALL pulse in that cycle.
REQ-013 SHALL implement FSM states IDLE, AUTO and MANUAL.
REQ-014 IDLE transitions: IDLE -> AUTO at the first frame boundary; in IDLE, pix_data = 16'h0000 and keys are ignored.
REQ-015 AUTO transitions: AUTO -> MANUAL on key_mode.
REQ-016 MANUAL transitions: MANUAL -> AUTO on key_mode; the transition takes effect the cycle after the pulse.
REQ-017 SHALL register pix_data from pix_data[pat_sel], giving 1 cycle latency from source input to output.
REQ-018 SHALL update pat_sel only on a frame boundary cycle, never mid-frame.
REQ-019 AUTO: a 10-bit dwell counter SHALL increment per boundary.
REQ-020 AUTO: at a boundary with counter == DWELL_FRAMES-1, pat_sel SHALL increment and the counter SHALL clear.
REQ-021 pat_sel SHALL wrap 3 -> 0.
REQ-022 MANUAL: key_next SHALL set a pending flag; at the next boundary pat_sel SHALL increment (wrapping) and pending SHALL clear.
REQ-023 MANUAL: multiple key_next pulses within one frame SHALL collapse to a single step.
REQ-024 key_next coincident with a boundary cycle SHALL be applied at that boundary.
REQ-025 key_next in AUTO or IDLE SHALL be ignored.
REQ-026 Any mode change SHALL clear the dwell counter and the pending flag.
REQ-027 key_mode and key_next in the same cycle: key_mode SHALL win and key_next SHALL be dropped.
REQ-028 key_mode coincident with an AUTO dwell-expiry boundary: the pat_sel step at that boundary SHALL still occur, then the mode SHALL change.
REQ-029 DWELL_FRAMES = 1 SHALL step the pattern every frame.

Reset
REQ-030 rst_n low SHALL asynchronously force state = IDLE, pat_sel = 0, pix_data = 0, auto_mode = 0, frame_start = 0, dwell counter = 0, pending = 0 and the vsync history register = 1.
REQ-031 Reset asserted mid-frame SHALL take effect immediately; after release the block SHALL wait for a fresh vsync falling edge and SHALL NOT treat release itself as a boundary.

Structure
REQ-032 Package vga_pkg SHALL hold: the state enum (IDLE/AUTO/MANUAL), PAT_W = 2, RGB_W = 16, COLOR_BLACK = 16'h0000.
REQ-033 SHALL contain exactly one sub-module, vga_edge_det: a registered falling-edge detector for vsync that produces frame_start.
REQ-034 All remaining logic (FSM, dwell counter, pending flag, output mux) SHALL be flat in vga_pat_sched.

Verification (bench uses DWELL_FRAMES = 3, sources set to constants 16'hF800, 16'h07E0, 16'h001F, 16'hFFFF)
REQ-035 Reset, then 1 vsync fall -> pix_data = 0 before the boundary, auto_mode = 1 after it; pat_sel = 0 and pix_data = 16'hF800 one cycle later.
REQ-036 AUTO, 7 further boundaries -> pat_sel changes at boundaries 3 and 6 (values 1, 2), each change exactly on the frame_start cycle, with pix_data following 1 cycle later.
REQ-037 key_mode, then 3 key_next pulses in one frame -> auto_mode = 0, pat_sel advances by exactly 1 at the next boundary; with no keys, pat_sel holds across 5 boundaries.
REQ-038 MANUAL at pat_sel = 3, key_next on the boundary cycle itself -> pat_sel = 0 that boundary; key_mode + key_next in the same cycle -> auto_mode = 1, pat_sel unchanged at the next boundary.
REQ-039 rst_n pulsed low mid-frame with pat_sel = 2 -> all outputs 0 asynchronously; after release, no frame_start until the next vsync fall.
